// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt response sequencer.
package int_pkg;

  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int ADDR_W_DEF       = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_JUMP  = 3'd2,
    ST_ISR   = 3'd3,
    ST_RET   = 3'd4
  } state_t;

endpackage

// File: rtl/int_responder_if.sv
// Bundle between the interrupt arbiter, the pipeline control and int_responder.
interface int_responder_if #(parameter int ADDR_W = int_pkg::ADDR_W_DEF);

  logic              Int;
  logic [ADDR_W-1:0] Iaddr;
  logic [ADDR_W-1:0] EPC;
  logic              eret_dec;
  logic              stall;
  logic              flush;
  logic              pc_sel;
  logic [ADDR_W-1:0] pc_target;
  logic              eret;
  logic              in_isr;
  logic              err;
  logic [15:0]       int_count;
  logic [31:0]       isr_cycles;

  modport master (
    output Int, Iaddr, EPC, eret_dec, stall,
    input  flush, pc_sel, pc_target, eret, in_isr, err, int_count, isr_cycles
  );

  modport slave (
    input  Int, Iaddr, EPC, eret_dec, stall,
    output flush, pc_sel, pc_target, eret, in_isr, err, int_count, isr_cycles
  );

endinterface

// File: rtl/int_stats.sv
// Interrupt statistics: saturating count of handler entries, wrapping cycles-in-handler.
module int_stats (
  input  logic        clk,
  input  logic        CLR,
  input  logic        take_i,
  input  logic        isr_i,
  output logic [15:0] int_count,
  output logic [31:0] isr_cycles
);

  logic [15:0] count_d, count_q;
  logic [31:0] cycles_d, cycles_q;

  // Next-value logic for both counters.
  always_comb begin
    count_d  = count_q;
    cycles_d = cycles_q;
    if (take_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
    if (isr_i) begin
      cycles_d = cycles_q + 32'd1;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Counter registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (CLR) begin
      count_q  <= 16'd0;
      cycles_q <= 32'd0;
    end else begin
      count_q  <= count_d;
      cycles_q <= cycles_d;
    end
  end

  assign int_count  = count_q;
  assign isr_cycles = cycles_q;

endmodule

// File: rtl/int_responder.sv
// Pipeline-side interrupt entry/return sequencer (IDLE/FLUSH/JUMP/ISR/RET).
// Optional statistics counters are built only when INT_STATS_EN is defined.
module int_responder
  import int_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input logic            clk,
  input logic            CLR,
  int_responder_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t            state_d, state_q;
  logic              pend_d, pend_q;
  logic [ADDR_W-1:0] iaddr_d, iaddr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              err_d, err_q;

  // Next-state, pending-request, handler-address and error logic.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    iaddr_d = iaddr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Int) begin
          iaddr_d = bus.Iaddr;
          if (!bus.stall) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_LOAD;
            pend_d  = 1'b0;
          end else begin
            pend_d  = 1'b1;
          end
        end else if (pend_q && !bus.stall) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
        if (bus.eret_dec) err_d = 1'b1; else err_d = err_q;
      end
      ST_FLUSH: begin
        if (!bus.stall) begin
          if (cnt_q == {CNT_W{1'b0}}) state_d = ST_JUMP;
          else cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_FLUSH;
        end
        if (bus.Int || bus.eret_dec) err_d = 1'b1; else err_d = err_q;
      end
      ST_JUMP: begin
        if (!bus.stall) state_d = ST_ISR; else state_d = ST_JUMP;
        if (bus.Int || bus.eret_dec) err_d = 1'b1; else err_d = err_q;
      end
      ST_ISR: begin
        if (bus.eret_dec && !bus.stall) state_d = ST_RET; else state_d = ST_ISR;
        if (bus.Int) err_d = 1'b1; else err_d = err_q;
      end
      ST_RET: begin
        // A new interrupt arriving while returning is queued, not an error.
        state_d = ST_IDLE;
        if (bus.Int) begin
          pend_d  = 1'b1;
          iaddr_d = bus.Iaddr;
        end else begin
          pend_d  = pend_q;
        end
        if (bus.eret_dec) err_d = 1'b1; else err_d = err_q;
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State and context registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      iaddr_q <= {ADDR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      iaddr_q <= iaddr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Moore output decode of the registered state.
  always_comb begin
    bus.flush     = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.pc_target = {ADDR_W{1'b0}};
    bus.eret      = 1'b0;
    bus.in_isr    = 1'b0;
    case (state_q)
      ST_IDLE:  bus.flush = 1'b0;
      ST_FLUSH: bus.flush = 1'b1;
      ST_JUMP: begin
        bus.flush     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.pc_target = iaddr_q;
      end
      ST_ISR:   bus.in_isr = 1'b1;
      ST_RET: begin
        bus.flush     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.pc_target = bus.EPC;
        bus.eret      = 1'b1;
      end
      default:  bus.flush = 1'b0;
    endcase
  end

  assign bus.err = err_q;

`ifdef INT_STATS_EN
  logic take_s;
  logic isr_s;

  assign take_s = (state_q == ST_JUMP) && !bus.stall;
  assign isr_s  = (state_q == ST_ISR);

  int_stats u_stats (
    .clk        (clk),
    .CLR        (CLR),
    .take_i     (take_s),
    .isr_i      (isr_s),
    .int_count  (bus.int_count),
    .isr_cycles (bus.isr_cycles)
  );
`else
  assign bus.int_count  = 16'd0;
  assign bus.isr_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_int_responder.sv
// Directed self-checking bench for int_responder (FLUSH_CYCLES=2, ADDR_W=32).
module tb_int_responder;

  logic clk;
  logic CLR;
  int   n_tests = 0;
  int   n_fail  = 0;

  int_responder_if #(.ADDR_W(32)) bus ();

  int_responder #(.FLUSH_CYCLES(2), .ADDR_W(32)) dut (
    .clk (clk),
    .CLR (CLR),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ctl = {flush, pc_sel, eret, in_isr, err}
  task automatic chk(input string tag, input logic [4:0] ctl, input logic [31:0] tgt);
    check_eq({tag, ".ctl"}, {27'd0, bus.flush, bus.pc_sel, bus.eret, bus.in_isr, bus.err}, {27'd0, ctl});
    check_eq({tag, ".tgt"}, bus.pc_target, tgt);
  endtask

  initial begin
    CLR = 1'b1;
    bus.Int = 1'b0; bus.Iaddr = 32'h0; bus.EPC = 32'h0;
    bus.eret_dec = 1'b0; bus.stall = 1'b0;
    step(2);
    CLR = 1'b0;
    chk("reset", 5'b00000, 32'h0);
    check_eq("reset.cnt", {16'd0, bus.int_count}, 32'd0);
    check_eq("reset.cyc", bus.isr_cycles, 32'd0);

    // Basic entry and return
    bus.Int = 1'b1; bus.Iaddr = 32'h9;
    step(1); bus.Int = 1'b0; bus.Iaddr = 32'h0;
    chk("t1_flush1", 5'b10000, 32'h0);
    step(1); chk("t1_flush2", 5'b10000, 32'h0);
    step(1); chk("t1_jump", 5'b11000, 32'h9);
    step(1); chk("t1_isr", 5'b00010, 32'h0);
    step(3); chk("t1_isr_hold", 5'b00010, 32'h0);
    bus.EPC = 32'h40; bus.eret_dec = 1'b1;
    step(1); bus.eret_dec = 1'b0;
    chk("t1_ret", 5'b11100, 32'h40);
    step(1); chk("t1_idle", 5'b00000, 32'h0);

    // Entry delayed by stall; handler address taken from the Int cycle
    bus.stall = 1'b1; bus.Int = 1'b1; bus.Iaddr = 32'h20;
    step(1); bus.Int = 1'b0; bus.Iaddr = 32'h55;
    chk("t2_stall1", 5'b00000, 32'h0);
    step(1); chk("t2_stall2", 5'b00000, 32'h0);
    step(1); chk("t2_stall3", 5'b00000, 32'h0);
    bus.stall = 1'b0;
    step(1); chk("t2_flush1", 5'b10000, 32'h0);
    step(1); chk("t2_flush2", 5'b10000, 32'h0);
    step(1); chk("t2_jump", 5'b11000, 32'h20);
    step(1); chk("t2_isr", 5'b00010, 32'h0);

    // Protocol errors are sticky and do not disturb the sequence
    bus.Int = 1'b1;
    step(1); bus.Int = 1'b0;
    chk("t3_int_in_isr", 5'b00011, 32'h0);
    step(1); chk("t3_sticky", 5'b00011, 32'h0);
    bus.EPC = 32'h44; bus.eret_dec = 1'b1;
    step(1); bus.eret_dec = 1'b0;
    chk("t3_ret", 5'b11101, 32'h44);
    step(1); chk("t3_idle", 5'b00001, 32'h0);
    bus.eret_dec = 1'b1;
    step(1); bus.eret_dec = 1'b0;
    chk("t3_eret_idle", 5'b00001, 32'h0);
    CLR = 1'b1;
    step(1); CLR = 1'b0;
    chk("t3_clr", 5'b00000, 32'h0);

    // Clear during FLUSH, then full sequence
    bus.Int = 1'b1; bus.Iaddr = 32'h77;
    step(1); bus.Int = 1'b0;
    chk("t4_flush", 5'b10000, 32'h0);
    CLR = 1'b1;
    step(1); CLR = 1'b0;
    chk("t4_clr", 5'b00000, 32'h0);
    step(1); chk("t4_idle", 5'b00000, 32'h0);
    bus.Int = 1'b1; bus.Iaddr = 32'hC8;
    step(1); bus.Int = 1'b0;
    chk("t4_flush1", 5'b10000, 32'h0);
    step(1); chk("t4_flush2", 5'b10000, 32'h0);
    step(1); chk("t4_jump", 5'b11000, 32'hC8);
    step(1); chk("t4_isr", 5'b00010, 32'h0);
    bus.EPC = 32'h100; bus.eret_dec = 1'b1;
    step(1); bus.eret_dec = 1'b0;
    chk("t4_ret", 5'b11100, 32'h100);

    // Int during RET is queued and serviced from IDLE
    bus.Int = 1'b1; bus.Iaddr = 32'h3C;
    step(1); bus.Int = 1'b0; bus.Iaddr = 32'h0;
    chk("t5_idle", 5'b00000, 32'h0);
    step(1); chk("t5_flush1", 5'b10000, 32'h0);
    step(1); chk("t5_flush2", 5'b10000, 32'h0);
    step(1); chk("t5_jump", 5'b11000, 32'h3C);
    step(1); chk("t5_isr", 5'b00010, 32'h0);
    bus.EPC = 32'h104; bus.eret_dec = 1'b1;
    step(1); bus.eret_dec = 1'b0;
    chk("t5_ret", 5'b11100, 32'h104);
    step(1); chk("t5_done", 5'b00000, 32'h0);

    // Three interrupts with 10-cycle handlers
    CLR = 1'b1;
    step(1); CLR = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.Int = 1'b1; bus.Iaddr = 32'h200 + k;
      step(1); bus.Int = 1'b0;
      step(3);
      step(9);
      bus.eret_dec = 1'b1;
      step(1); bus.eret_dec = 1'b0;
      step(1);
    end
    chk("t6_idle", 5'b00000, 32'h0);
`ifdef INT_STATS_EN
    check_eq("t6_int_count", {16'd0, bus.int_count}, 32'd3);
    check_eq("t6_isr_cycles", bus.isr_cycles, 32'd30);
`else
    check_eq("t6_int_count", {16'd0, bus.int_count}, 32'd0);
    check_eq("t6_isr_cycles", bus.isr_cycles, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
